// File: rtl/decode_var_pipe_if.sv
// Handshake bundle for decode_var_pipe: upstream code/mode stream in, decoded word out.
// The slave modport is the decoder's view; the master modport is the side that drives it.
interface decode_var_pipe_if #(
    parameter int IN_W  = 4,
    parameter int CNT_W = 16
);
    localparam int OUT_W = 2 ** IN_W;

    logic             valid_in;
    logic             ready_out;
    logic [IN_W-1:0]  data_in;
    logic [1:0]       mode_in;
    logic             valid_out;
    logic             ready_in;
    logic [OUT_W-1:0] decode_out;
    logic             err_out;
    logic [CNT_W-1:0] cnt_out;

    modport slave (
        input  valid_in, data_in, mode_in, ready_in,
        output ready_out, valid_out, decode_out, err_out, cnt_out
    );

    modport master (
        output valid_in, data_in, mode_in, ready_in,
        input  ready_out, valid_out, decode_out, err_out, cnt_out
    );
endinterface

// File: rtl/decode_var_pipe.sv
// Registered N-to-2^N decoder (one-hot / thermometer / inverted one-hot) behind a
// two-entry skid buffer, with out-of-range flagging and an accepted-word counter.
module decode_var_pipe #(
    parameter int IN_W     = 4,
    parameter int MAX_CODE = 2 ** IN_W - 1,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    decode_var_pipe_if.slave   bus
);
    localparam int OUT_W = 2 ** IN_W;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        MODE_ONEHOT = 2'b00,
        MODE_THERM  = 2'b01,
        MODE_INV    = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_e;

    state_e           state_q, state_d;
    logic             valid_q, valid_d;
    logic             ready_q, ready_d;
    logic [OUT_W-1:0] out_word_q, out_word_d;
    logic             out_err_q, out_err_d;
    logic [OUT_W-1:0] skid_word_q, skid_word_d;
    logic             skid_err_q, skid_err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    mode_e            mode;
    logic [OUT_W-1:0] one_hot;
    logic [OUT_W-1:0] dec_word;
    logic             dec_err;
    logic             acc;
    logic             xfer;

    assign acc  = bus.valid_in && ready_q;
    assign xfer = valid_q && bus.ready_in;

    // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        mode     = mode_e'(bus.mode_in);
        one_hot  = OUT_W'(1) << bus.data_in;
        dec_err  = (int'(bus.data_in) > MAX_CODE) || (mode == MODE_RSVD);
        dec_word = '0;
        if (dec_err) begin
            // An error word asserts nothing: all-zero, except all-one in the active-low mode.
            dec_word = (mode == MODE_INV) ? '1 : '0;
        end else begin
            case (mode)
                MODE_ONEHOT: dec_word = one_hot;
                // Shifting the top bit out wraps to zero, so the subtraction yields all ones.
                MODE_THERM:  dec_word = (one_hot << 1) - OUT_W'(1);
                MODE_INV:    dec_word = ~one_hot;
                default:     dec_word = '0;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        out_word_d  = out_word_q;
        out_err_d   = out_err_q;
        skid_word_d = skid_word_q;
        skid_err_d  = skid_err_q;
        cnt_d       = cnt_q + CNT_W'(acc);

        case (state_q)
            ST_EMPTY: begin
                if (acc) begin
                    out_word_d = dec_word;
                    out_err_d  = dec_err;
                    state_d    = ST_ONE;
                end
            end
            ST_ONE: begin
                if (acc && !xfer) begin
                    skid_word_d = dec_word;
                    skid_err_d  = dec_err;
                    state_d     = ST_TWO;
                end else if (acc && xfer) begin
                    out_word_d = dec_word;
                    out_err_d  = dec_err;
                end else if (xfer) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (xfer) begin
                    out_word_d = skid_word_q;
                    out_err_d  = skid_err_q;
                    state_d    = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        // Handshake flags are registered from the next state so neither depends on the ports combinationally.
        valid_d = (state_d != ST_EMPTY);
        ready_d = (state_d != ST_TWO);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    // NOTE: the skid storage is reset along with the control flops; it is only two words, and known values keep DECODE_OUT at zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            valid_q     <= 1'b0;
            ready_q     <= 1'b1;
            out_word_q  <= '0;
            out_err_q   <= 1'b0;
            skid_word_q <= '0;
            skid_err_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            ready_q     <= ready_d;
            out_word_q  <= out_word_d;
            out_err_q   <= out_err_d;
            skid_word_q <= skid_word_d;
            skid_err_q  <= skid_err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.ready_out  = ready_q;
    assign bus.valid_out  = valid_q;
    assign bus.decode_out = out_word_q;
    assign bus.err_out    = out_err_q;
    assign bus.cnt_out    = cnt_q;
endmodule

// File: tb/tb_decode_var_pipe.sv
// Scoreboard bench: two decoders (4-bit full range, 5-bit with MAX_CODE=20) share one stimulus
// stream; expected words come from an arithmetic reference model, monitors pop and compare.
module tb_decode_var_pipe;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    decode_var_pipe_if #(.IN_W(4), .CNT_W(16)) if4 ();
    decode_var_pipe_if #(.IN_W(5), .CNT_W(16)) if5 ();

    decode_var_pipe #(.IN_W(4), .CNT_W(16)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if4.slave)
    );

    decode_var_pipe #(.IN_W(5), .MAX_CODE(20), .CNT_W(16)) dut5 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if5.slave)
    );

    typedef struct packed {
        logic [63:0] word;
        logic        err;
    } exp_t;

    exp_t q4[$];
    exp_t q5[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   acc_cnt  = 0;
    int   xfer4    = 0;
    int   xfer5    = 0;
    bit   last_acc = 1'b0;
    bit   held4_v  = 1'b0;
    bit   held5_v  = 1'b0;
    logic [63:0] held4_w, held5_w;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Reference: output width is 2**w bits; an illegal code or reserved mode asserts no bit.
    function automatic logic [63:0] ref_word(int w, int max_code, int mode, int code, output bit err);
        logic [63:0] mask;
        mask = (64'd1 << (1 << w)) - 64'd1;
        err  = (code > max_code) || (mode == 3);
        if (err) return (mode == 2) ? mask : 64'd0;
        case (mode)
            0:       return 64'd1 << code;
            1:       return (64'd2 << code) - 64'd1;
            default: return ~(64'd1 << code) & mask;
        endcase
    endfunction

    task automatic drive(bit v, int mode, int code, bit rdy);
        bit          e;
        logic [63:0] w;
        @(negedge clk);
        if4.valid_in = v;           if5.valid_in = v;
        if4.mode_in  = 2'(mode);    if5.mode_in  = 2'(mode);
        if4.data_in  = 4'(code);    if5.data_in  = 5'(code);
        if4.ready_in = rdy;         if5.ready_in = rdy;
        last_acc = v && if4.ready_out;
        if (last_acc) begin
            w = ref_word(4, 15, mode, code & 15, e);
            q4.push_back('{word: w, err: e});
            w = ref_word(5, 20, mode, code & 31, e);
            q5.push_back('{word: w, err: e});
            acc_cnt++;
        end
    endtask

    task automatic send(int mode, int code, bit rdy);
        int tries = 0;
        do begin
            drive(1'b1, mode, code, rdy);
            tries++;
        end while (!last_acc && tries < 50);
        if (!last_acc) begin
            n_checks++;
            $display("FAIL send_timeout: got no accept, expected accept within 50 cycles");
        end
    endtask

    task automatic idle(int n, bit rdy);
        repeat (n) drive(1'b0, 0, 0, rdy);
    endtask

    // Monitors sample 1 time unit after the falling edge, seeing the ready_in that the next rising edge will use.
    always @(negedge clk) begin
        exp_t e;
        #1;
        if (rst_n) begin
            if (held4_v) check("hold4", 64'(if4.decode_out), held4_w);
            held4_v = if4.valid_out && !if4.ready_in;
            held4_w = 64'(if4.decode_out);
            if (if4.valid_out && if4.ready_in) begin
                xfer4++;
                if (q4.size() == 0) begin
                    n_checks++;
                    $display("FAIL out4_extra: got word %0h, expected none", if4.decode_out);
                end else begin
                    e = q4.pop_front();
                    check("data4", 64'(if4.decode_out), e.word);
                    check("err4", 64'(if4.err_out), 64'(e.err));
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        #1;
        if (rst_n) begin
            if (held5_v) check("hold5", 64'(if5.decode_out), held5_w);
            held5_v = if5.valid_out && !if5.ready_in;
            held5_w = 64'(if5.decode_out);
            if (if5.valid_out && if5.ready_in) begin
                xfer5++;
                if (q5.size() == 0) begin
                    n_checks++;
                    $display("FAIL out5_extra: got word %0h, expected none", if5.decode_out);
                end else begin
                    e = q5.pop_front();
                    check("data5", 64'(if5.decode_out), e.word);
                    check("err5", 64'(if5.err_out), 64'(e.err));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic check_reset_values(string tag);
        check({tag, "_valid4"}, 64'(if4.valid_out), 64'd0);
        check({tag, "_ready4"}, 64'(if4.ready_out), 64'd1);
        check({tag, "_dec4"},   64'(if4.decode_out), 64'd0);
        check({tag, "_err4"},   64'(if4.err_out), 64'd0);
        check({tag, "_cnt4"},   64'(if4.cnt_out), 64'd0);
        check({tag, "_valid5"}, 64'(if5.valid_out), 64'd0);
        check({tag, "_ready5"}, 64'(if5.ready_out), 64'd1);
        check({tag, "_dec5"},   64'(if5.decode_out), 64'd0);
        check({tag, "_cnt5"},   64'(if5.cnt_out), 64'd0);
    endtask

    task automatic check_drained(string tag);
        check({tag, "_q4_empty"}, 64'(q4.size()), 64'd0);
        check({tag, "_q5_empty"}, 64'(q5.size()), 64'd0);
        check({tag, "_cnt4"}, 64'(if4.cnt_out), 64'(acc_cnt & 16'hFFFF));
        check({tag, "_cnt5"}, 64'(if5.cnt_out), 64'(acc_cnt & 16'hFFFF));
    endtask

    initial begin
        int x0;
        rst_n = 1'b0;
        if4.valid_in = 1'b0; if4.ready_in = 1'b0; if4.data_in = '0; if4.mode_in = '0;
        if5.valid_in = 1'b0; if5.ready_in = 1'b0; if5.data_in = '0; if5.mode_in = '0;
        #22;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;
        idle(2, 1'b1);

        // Back-to-back one-hot stream: 16 transfers must land on 16 consecutive edges.
        x0 = xfer4;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 0, i, 1'b1);
            check("stream_acc", 64'(last_acc), 64'd1);
        end
        drive(1'b0, 0, 0, 1'b1);
        #2;
        check("stream_no_gap", 64'(xfer4 - x0), 64'd16);
        check("stream_cnt", 64'(if4.cnt_out), 64'd16);
        idle(2, 1'b1);

        // Thermometer and inverted one-hot.
        send(1, 0, 1'b1);
        send(1, 7, 1'b1);
        send(1, 15, 1'b1);
        send(2, 3, 1'b1);
        // Boundary and illegal codes (illegal only on the 5-bit, MAX_CODE=20 decoder).
        send(0, 20, 1'b1);
        send(0, 21, 1'b1);
        send(0, 31, 1'b1);
        send(3, 2, 1'b1);
        send(2, 25, 1'b1);
        idle(3, 1'b1);
        check_drained("directed");

        // Back-pressure: two words fill the buffer, the third is held upstream.
        drive(1'b1, 0, 1, 1'b0);
        drive(1'b1, 0, 2, 1'b0);
        drive(1'b1, 0, 3, 1'b0);
        #2;
        check("bp_no_accept", 64'(last_acc), 64'd0);
        check("bp_ready_low", 64'(if4.ready_out), 64'd0);
        check("bp_out_word", 64'(if4.decode_out), 64'h0002);
        drive(1'b1, 0, 3, 1'b0);
        #2;
        check("bp_still_held", 64'(if5.decode_out), 64'h0002);
        x0 = xfer4;
        send(0, 3, 1'b1);
        idle(1, 1'b1);
        #2;
        check("bp_drain_no_gap", 64'(xfer4 - x0), 64'd3);
        idle(2, 1'b1);
        check_drained("backpressure");

        // Random traffic: valid ~50%, ready ~75%, any code and mode.
        for (int i = 0; i < 1000; i++) begin
            drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 31)), $urandom_range(0, 3) != 0);
        end
        idle(5, 1'b1);
        check_drained("random");

        // Reset while both entries are occupied.
        drive(1'b1, 1, 4, 1'b0);
        drive(1'b1, 1, 6, 1'b0);
        drive(1'b0, 0, 0, 1'b0);
        #2;
        check("two_ready_low", 64'(if4.ready_out), 64'd0);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_values("midreset");
        q4.delete();
        q5.delete();
        acc_cnt = 0;
        held4_v = 1'b0;
        held5_v = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        send(1, 9, 1'b1);
        idle(3, 1'b1);
        check_drained("post_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
